// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
package booth_pkg;

  localparam int BOOTH_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } booth_state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of the concatenation {A,Q,q_1}. Purely combinational.
module booth_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   a_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             q_1_nxt
);

  logic [WIDTH:0] sum;

  // Recode {Q[0],q_1}, apply the add/sub, then shift everything right by one
  // keeping the accumulator sign bit.
  always_comb begin
    sum = a;
    case ({q[0], q_1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    a_nxt   = {sum[WIDTH], sum[WIDTH:1]};
    q_nxt   = {sum[0], q[WIDTH-1:1]};
    q_1_nxt = q[0];
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed multiplier, radix-2 Booth. One step per cycle, product
// available WIDTH cycles after start is sampled in IDLE.
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   num_1,
  input  logic signed [WIDTH-1:0]   num_2,
  output logic                      mult_ready,
  output logic signed [2*WIDTH-1:0] mult
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  booth_state_t   state;
  // One extra accumulator bit keeps -2^(W-1) * -2^(W-1) exact.
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [WIDTH:0]   m;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   a_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             q_1_nxt;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a       (a),
    .q       (q),
    .q_1     (q_1),
    .m       (m),
    .a_nxt   (a_nxt),
    .q_nxt   (q_nxt),
    .q_1_nxt (q_1_nxt)
  );

  assign mult_ready = (state == DONE);

  // Control FSM and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a     <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      m     <= '0;
      count <= '0;
      mult  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a     <= '0;
            q     <= num_2;
            q_1   <= 1'b0;
            m     <= {num_1[WIDTH-1], num_1};
            count <= CNT_W'(WIDTH);
            state <= CALC;
          end
        end
        CALC: begin
          a     <= a_nxt;
          q     <= q_nxt;
          q_1   <= q_1_nxt;
          count <= count - CNT_W'(1);
          // Last step: the product is the low 2W bits of the shifted {A,Q}.
          if (count == CNT_W'(1)) begin
            mult  <= {a_nxt[WIDTH-1:0], q_nxt};
            state <= DONE;
          end
        end
        DONE: begin
          // A held start must not retrigger; wait for it to drop.
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier: latency, products, reset abort,
// operand isolation and start handshake.
module tb_booth_multiplier;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic signed [7:0]  num_1 = '0;
  logic signed [7:0]  num_2 = '0;
  logic               mult_ready;
  logic signed [15:0] mult;

  int errors = 0;
  int checks = 0;

  booth_multiplier #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_1      (num_1),
    .num_2      (num_2),
    .mult_ready (mult_ready),
    .mult       (mult)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Assumes IDLE with start low. Launches a multiply, checks exact latency
  // and product, then drops start and checks return to IDLE.
  task automatic mul(input string tag, input logic signed [7:0] a, input logic signed [7:0] b,
                     input logic [15:0] exp, input bit scramble);
    num_1 = a;
    num_2 = b;
    start = 1'b1;
    @(negedge clk);                       // after e0
    chk({tag, "_rdy_e0"}, {15'd0, mult_ready}, 16'd0);
    repeat (2) @(negedge clk);
    if (scramble) begin
      num_1 = 8'sd127;
      num_2 = -8'sd77;
    end
    repeat (5) @(negedge clk);            // after e7
    chk({tag, "_rdy_e7"}, {15'd0, mult_ready}, 16'd0);
    @(negedge clk);                       // after e8
    chk({tag, "_rdy_e8"}, {15'd0, mult_ready}, 16'd1);
    chk({tag, "_prod"}, mult, exp);
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy_idle"}, {15'd0, mult_ready}, 16'd0);
    chk({tag, "_hold"}, mult, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rdy", {15'd0, mult_ready}, 16'd0);
    chk("rst_mult", mult, 16'd0);
    reset = 1'b0;

    // 45*71 with start held through DONE
    num_1 = 8'sd45;
    num_2 = 8'sd71;
    start = 1'b1;
    @(negedge clk);
    repeat (7) @(negedge clk);
    chk("t1_rdy_e7", {15'd0, mult_ready}, 16'd0);
    @(negedge clk);
    chk("t1_rdy_e8", {15'd0, mult_ready}, 16'd1);
    chk("t1_prod", mult, 16'd3195);
    repeat (4) @(negedge clk);
    chk("t1_held_rdy", {15'd0, mult_ready}, 16'd1);
    chk("t1_held_prod", mult, 16'd3195);
    start = 1'b0;
    @(negedge clk);
    chk("t1_idle_rdy", {15'd0, mult_ready}, 16'd0);
    chk("t1_idle_prod", mult, 16'd3195);

    // Fresh reset, then the spec's negative cases
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_mult", mult, 16'd0);
    reset = 1'b0;
    mul("m87x46", 8'b10101001, 8'sd46, 16'hF05E, 1'b0);
    mul("99x97", 8'sd99, 8'sd97, 16'd9603, 1'b0);
    mul("m128sq", -8'sd128, -8'sd128, 16'd16384, 1'b0);
    mul("m1x127", -8'sd1, 8'sd127, 16'hFF81, 1'b0);
    mul("127xm128", 8'sd127, -8'sd128, 16'hC080, 1'b0);

    // Reset 4 cycles into CALC aborts; start high alongside reset is ignored
    num_1 = 8'sd100;
    num_2 = -8'sd3;
    start = 1'b1;
    repeat (5) @(negedge clk);            // after e4
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rdy", {15'd0, mult_ready}, 16'd0);
    chk("abort_mult", mult, 16'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort_idle", {15'd0, mult_ready}, 16'd0);
    mul("after_abort", 8'sd12, -8'sd11, 16'hFF7C, 1'b0);

    // Operands changed mid-CALC must not disturb the result
    mul("scramble", 8'sd25, -8'sd6, 16'hFF6A, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
